// File: rtl/fib_chk_pkg.sv
// Shared types and default sizing for the Fibonacci stream checker.
//   fib_state_e : checker FSM states (HUNT0 / HUNT1 / LOCK)
//   FIB_*       : default sample width, counter width and preseed terms
package fib_chk_pkg;

  localparam int unsigned FIB_W      = 8;
  localparam int unsigned FIB_CNT_W  = 16;
  localparam int unsigned FIB_SEED_A = 0;
  localparam int unsigned FIB_SEED_B = 1;

  typedef enum logic [1:0] {
    HUNT0 = 2'd0,
    HUNT1 = 2'd1,
    LOCK  = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_sat_cnt.sv
// Saturating up-counter: holds at all-ones once reached.
//   clk : rising-edge clock
//   clr : synchronous clear, wins over inc
//   inc : count one event this cycle
//   cnt : registered count value
module fib_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fib_stream_checker.sv
// Receive-side checker for the Fibonacci step stream: locks onto
// x(n) = x(n-1) + x(n-2) mod 2^W, flags breaks and counts matches/errors.
// Optional feature macro: FIB_CHK_PRESEED_EN (reset straight into LOCK
// with a = SEED_A, b = SEED_B so the very first sample is checked).
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (wins over samp_valid)
//   samp_valid : samp_data holds a new generator term this cycle
//   samp_data  : sample value (W bits)
//   lock       : checker is tracking the recurrence
//   mismatch   : one-cycle pulse, last accepted sample broke the recurrence
//   expected   : next predicted term in LOCK, else 0
//   match_cnt  : saturating count of matching samples
//   err_cnt    : saturating count of mismatches
module fib_stream_checker
  import fib_chk_pkg::*;
#(
  parameter int unsigned W      = FIB_W,
  parameter int unsigned CNT_W  = FIB_CNT_W,
  parameter int unsigned SEED_A = FIB_SEED_A,
  parameter int unsigned SEED_B = FIB_SEED_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             samp_valid,
  input  logic [W-1:0]     samp_data,
  output logic             lock,
  output logic             mismatch,
  output logic [W-1:0]     expected,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

`ifdef FIB_CHK_PRESEED_EN
  localparam bit         PRESEED   = 1'b1;
  localparam fib_state_e RST_STATE = LOCK;
`else
  localparam bit         PRESEED   = 1'b0;
  localparam fib_state_e RST_STATE = HUNT0;
`endif

  // Reset image of the term registers and the derived outputs.
  localparam logic [W-1:0] RST_A   = PRESEED ? W'(SEED_A) : '0;
  localparam logic [W-1:0] RST_B   = PRESEED ? W'(SEED_B) : '0;
  localparam logic [W-1:0] RST_EXP = PRESEED ? W'(RST_A + RST_B) : '0;

  fib_state_e   state_q, state_d;
  logic [W-1:0] a_q, b_q, a_d, b_d;
  logic [W-1:0] sum_c;
  logic [W-1:0] expected_d;
  logic         mismatch_d;
  logic         match_inc;
  logic         err_inc;

  // Prediction from the two most recent terms, truncated to W bits.
  assign sum_c = W'(a_q + b_q);

  // Next-state, term update and event strobes.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mismatch_d = 1'b0;
    match_inc  = 1'b0;
    err_inc    = 1'b0;

    if (samp_valid) begin
      case (state_q)
        HUNT0: begin
          a_d     = samp_data;
          state_d = HUNT1;
        end
        HUNT1: begin
          b_d     = samp_data;
          state_d = LOCK;
        end
        LOCK: begin
          if (samp_data == sum_c) begin
            a_d       = b_q;
            b_d       = samp_data;
            match_inc = 1'b1;
          end else begin
            // The offending sample becomes the first term of the reseed.
            a_d        = samp_data;
            mismatch_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = HUNT1;
          end
        end
        default: begin
          state_d = RST_STATE;
        end
      endcase
    end
  end

  // Prediction registered alongside the state so it lines up with lock.
  assign expected_d = (state_d == LOCK) ? W'(a_d + b_d) : '0;

  // State, term registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      a_q      <= RST_A;
      b_q      <= RST_B;
      lock     <= PRESEED;
      mismatch <= 1'b0;
      expected <= RST_EXP;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      lock     <= (state_d == LOCK);
      mismatch <= mismatch_d;
      expected <= expected_d;
    end
  end

  fib_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .clr (rst),
    .inc (match_inc),
    .cnt (match_cnt)
  );

  fib_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .clr (rst),
    .inc (err_inc),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_fib_stream_checker.sv
// Scoreboard bench for fib_stream_checker (W=8, CNT_W=4 so saturation is
// reachable). The driver pushes the hand-computed post-edge output image for
// every cycle it drives; a monitor pops and compares on the falling edge.
// Build with FIB_CHK_PRESEED_EN to exercise the preseeded reset instead.
module tb_fib_stream_checker;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             samp_valid;
  logic [W-1:0]     samp_data;
  logic             lock;
  logic             mismatch;
  logic [W-1:0]     expected;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;

  typedef struct {
    logic             lk;
    logic             mm;
    logic [W-1:0]     ex;
    logic [CNT_W-1:0] mc;
    logic [CNT_W-1:0] ec;
    string            nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  fib_stream_checker #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .samp_valid (samp_valid),
    .samp_data  (samp_data),
    .lock       (lock),
    .mismatch   (mismatch),
    .expected   (expected),
    .match_cnt  (match_cnt),
    .err_cnt    (err_cnt)
  );

  // Drive one cycle and queue the outputs it must produce after the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input logic lk, input logic mm, input logic [W-1:0] ex,
                      input logic [CNT_W-1:0] mc, input logic [CNT_W-1:0] ec,
                      input string nm);
    exp_t e;
    rst        = r;
    samp_valid = v;
    samp_data  = d;
    @(posedge clk);
    e.lk = lk; e.mm = mm; e.ex = ex; e.mc = mc; e.ec = ec; e.nm = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs are registered, so every queued entry is due on the
  // falling edge after the edge that consumed its stimulus.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (lock !== e.lk || mismatch !== e.mm || expected !== e.ex ||
          match_cnt !== e.mc || err_cnt !== e.ec) begin
        $display("FAIL %s: got lock=%0d mm=%0d exp=%02h mc=%0d ec=%0d, want lock=%0d mm=%0d exp=%02h mc=%0d ec=%0d",
                 e.nm, lock, mismatch, expected, match_cnt, err_cnt,
                 e.lk, e.mm, e.ex, e.mc, e.ec);
      end else begin
        passes++;
      end
    end
  end

`ifndef FIB_CHK_PRESEED_EN
  // Clean stream and the output image after each sample.
  logic [W-1:0]     s1_d  [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h0D};
  logic             s1_lk [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [W-1:0]     s1_ex [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h0D, 8'h15};
  logic [CNT_W-1:0] s1_mc [8] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
`endif

  initial begin
    logic [W-1:0]     fa;
    logic [W-1:0]     fb;
    logic [W-1:0]     fd;
    logic [CNT_W-1:0] cnt_exp;

    rst        = 1'b1;
    samp_valid = 1'b0;
    samp_data  = '0;

`ifdef FIB_CHK_PRESEED_EN
    step(1, 0, 8'h00, 1, 0, 8'h01, 0, 0, "preseed_reset");
    step(0, 0, 8'h00, 1, 0, 8'h01, 0, 0, "preseed_idle");
    step(0, 1, 8'h01, 1, 0, 8'h02, 1, 0, "preseed_first");
    step(0, 1, 8'h02, 1, 0, 8'h03, 2, 0, "preseed_second");
    step(0, 1, 8'h09, 0, 1, 8'h00, 2, 1, "preseed_break");
`else
    step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, "reset0");
    step(1, 1, 8'h33, 0, 0, 8'h00, 0, 0, "reset1");

    // Clean stream, valid every cycle.
    for (int i = 0; i < 8; i++)
      step(0, 1, s1_d[i], s1_lk[i], 0, s1_ex[i], s1_mc[i], 0, $sformatf("clean_%0d", i));
    step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, "clean_rst");

    // Same stream with valid pattern 1,0,0: outputs hold through gaps.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, s1_d[i], s1_lk[i], 0, s1_ex[i], s1_mc[i], 0, $sformatf("gap_s%0d", i));
      step(0, 0, 8'hAA, s1_lk[i], 0, s1_ex[i], s1_mc[i], 0, $sformatf("gap_h%0da", i));
      step(0, 0, 8'h55, s1_lk[i], 0, s1_ex[i], s1_mc[i], 0, $sformatf("gap_h%0db", i));
    end

    // Reset while locked discards the sample presented with it.
    step(1, 1, 8'h15, 0, 0, 8'h00, 0, 0, "midrst");
    step(0, 1, 8'h21, 0, 0, 8'h00, 0, 0, "midrst_hunt0");
    step(0, 1, 8'h22, 1, 0, 8'h43, 0, 0, "midrst_hunt1");
    step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, "wrap_rst");

    // Sums wrap modulo 256.
    step(0, 1, 8'h59, 0, 0, 8'h00, 0, 0, "wrap_seed_a");
    step(0, 1, 8'h90, 1, 0, 8'hE9, 0, 0, "wrap_seed_b");
    step(0, 1, 8'hE9, 1, 0, 8'h79, 1, 0, "wrap_e9");
    step(0, 1, 8'h79, 1, 0, 8'h62, 2, 0, "wrap_79");
    step(0, 1, 8'h62, 1, 0, 8'hDB, 3, 0, "wrap_62");
    step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, "brk_rst");

    // Break: 07 is wrong, becomes first term of the reseed (07,08).
    step(0, 1, 8'h01, 0, 0, 8'h00, 0, 0, "brk_seed_a");
    step(0, 1, 8'h01, 1, 0, 8'h02, 0, 0, "brk_seed_b");
    step(0, 1, 8'h02, 1, 0, 8'h03, 1, 0, "brk_match");
    step(0, 1, 8'h07, 0, 1, 8'h00, 1, 1, "brk_bad");
    step(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, "brk_pulse_end");
    step(0, 1, 8'h08, 1, 0, 8'h0F, 1, 1, "brk_relock");
    step(0, 1, 8'h0F, 1, 0, 8'h17, 2, 1, "brk_rematch");
    step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, "sat_rst");

    // Saturation: 20 matches from 00,01 pin match_cnt at 15.
    step(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, "sat_seed_a");
    step(0, 1, 8'h01, 1, 0, 8'h01, 0, 0, "sat_seed_b");
    fa = 8'h00;
    fb = 8'h01;
    for (int i = 0; i < 20; i++) begin
      fd = fa + fb;
      fa = fb;
      fb = fd;
      cnt_exp = (i + 1 >= 15) ? 4'hF : CNT_W'(i + 1);
      step(0, 1, fd, 1, 0, W'(fa + fb), cnt_exp, 0, $sformatf("sat_match_%0d", i));
    end

    // Error saturation: alternate a bad 05 and a reseeding 05 (pred 0A).
    for (int k = 1; k <= 17; k++) begin
      cnt_exp = (k >= 15) ? 4'hF : CNT_W'(k);
      step(0, 1, 8'h05, 0, 1, 8'h00, 4'hF, cnt_exp, $sformatf("sat_err_%0d", k));
      step(0, 1, 8'h05, 1, 0, 8'h0A, 4'hF, cnt_exp, $sformatf("sat_reseed_%0d", k));
    end
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
